// File: rtl/sync_fifo_gen2.sv
// Single-clock FIFO for any DEPTH >= 2, with occupancy count, threshold flags and registered read data.
// Define SYNC_FIFO_GEN2_ERR_EN to build the sticky overflow/underflow error flags.
module sync_fifo_gen2 #(
  parameter int DATA_WID      = 8,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [DATA_WID-1:0]        data_in,
  input  logic                       rd_en,
  output logic [DATA_WID-1:0]        data_out,
  output logic                       data_vld,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WID-1:0] r_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [DATA_WID-1:0] r_data_out;
  logic                r_data_vld;

  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;

  // A write into a full FIFO is legal only when a read frees a slot on the same edge.
  assign w_rd_acc = rd_en && !empty;
  assign w_wr_acc = wr_en && (!full || w_rd_acc);

  // Explicit wrap so non-power-of-two depths use every entry.
  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  always_ff @(posedge clk) begin
    if (rstn && w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_data_vld <= 1'b0;
    end else begin
      r_data_vld <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= w_rd_ptr_nxt;
        r_data_out <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_out     = r_data_out;
  assign data_vld     = r_data_vld;
  assign count        = r_count;
  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CW'(AFULL_THRESH));
  assign almost_empty = (r_count <= CW'(AEMPTY_THRESH));

`ifdef SYNC_FIFO_GEN2_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky until reset; a rejected request leaves pointers, count and memory untouched.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && !w_wr_acc) r_overflow  <= 1'b1;
      if (rd_en && empty)     r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
